// File: rtl/arp_rx.sv
// arp_rx: GMII receive-side ARP parser. Walks preamble/SFD, the Ethernet
// header and the 28-byte ARP payload one byte per clk, and reports each
// valid request/reply addressed to BOARD_MAC (or broadcast) and BOARD_IP.
// Optional build macro ARP_RX_CRC_CHK_EN: the FCS is also checked and
// done is deferred until rx_dv falls.

`ifdef ARP_RX_CRC_CHK_EN
// crc32_d8: one byte step of the reflected Ethernet CRC-32 (LSB first).
module crc32_d8 (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  // Eight serial shifts of the reflected polynomial 0xEDB88320.
  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0] ^ data[i]) crc_out = (crc_out >> 1) ^ 32'hEDB8_8320;
      else                      crc_out = crc_out >> 1;
    end
  end
endmodule
`endif

module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

`ifdef ARP_RX_CRC_CHK_EN
  typedef enum logic [2:0] {IDLE, PRE, HEAD, DATA, CRC, WAIT_END} state_t;
`else
  typedef enum logic [2:0] {IDLE, PRE, HEAD, DATA, WAIT_END} state_t;
`endif

  state_t      state;
  logic [5:0]  cnt;          // preamble length in PRE, byte index in HEAD/DATA
  logic        uni_ok;       // dest MAC still matches BOARD_MAC so far
  logic        bc_ok;        // dest MAC still matches broadcast so far
  logic        op_type;      // op[1] of the frame in flight
  logic [47:0] shadow_mac;
  logic [31:0] shadow_ip;

  logic [7:0]  mac_byte;
  logic [7:0]  ip_byte;
  logic        uni_next;
  logic        bc_next;
  logic        head_bad;
  logic        data_bad;

  // Expected local-address byte for the current byte index.
  always_comb begin
    mac_byte = 8'h00;
    case (cnt)
      6'd0:    mac_byte = BOARD_MAC[47:40];
      6'd1:    mac_byte = BOARD_MAC[39:32];
      6'd2:    mac_byte = BOARD_MAC[31:24];
      6'd3:    mac_byte = BOARD_MAC[23:16];
      6'd4:    mac_byte = BOARD_MAC[15:8];
      6'd5:    mac_byte = BOARD_MAC[7:0];
      default: mac_byte = 8'h00;
    endcase
    // Target IP occupies DATA bytes 24..27, so the low two index bits select.
    case (cnt[1:0])
      2'd0:    ip_byte = BOARD_IP[31:24];
      2'd1:    ip_byte = BOARD_IP[23:16];
      2'd2:    ip_byte = BOARD_IP[15:8];
      default: ip_byte = BOARD_IP[7:0];
    endcase
  end

  // Per-byte field checks for the header and the ARP payload.
  always_comb begin
    uni_next = uni_ok && (gmii_rxd == mac_byte);
    bc_next  = bc_ok && (gmii_rxd == 8'hFF);
    head_bad = 1'b0;
    if (cnt <= 6'd5)       head_bad = !(uni_next || bc_next);
    else if (cnt == 6'd12) head_bad = (gmii_rxd != 8'h08);
    else if (cnt == 6'd13) head_bad = (gmii_rxd != 8'h06);
    data_bad = 1'b0;
    case (cnt)
      6'd0, 6'd3, 6'd6:     data_bad = (gmii_rxd != 8'h00);
      6'd1:                 data_bad = (gmii_rxd != 8'h01);
      6'd2:                 data_bad = (gmii_rxd != 8'h08);
      6'd4:                 data_bad = (gmii_rxd != 8'h06);
      6'd5:                 data_bad = (gmii_rxd != 8'h04);
      6'd7:                 data_bad = (gmii_rxd != 8'h01) && (gmii_rxd != 8'h02);
      6'd24, 6'd25, 6'd26,
      6'd27:                data_bad = (gmii_rxd != ip_byte);
      default:              data_bad = 1'b0;
    endcase
  end

`ifdef ARP_RX_CRC_CHK_EN
  logic [31:0] dly;          // last four bytes; oldest in [31:24]
  logic [6:0]  len;          // bytes from dest MAC on, saturating
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [31:0] fcs;
  logic        fcs_ok;

  crc32_d8 u_crc (.crc_in(crc), .data(dly[31:24]), .crc_out(crc_next));

  // The four bytes still in the delay line at rx_dv fall are the FCS,
  // transmitted low byte of the inverted CRC first.
  always_comb begin
    fcs    = ~crc;
    fcs_ok = (dly == {fcs[7:0], fcs[15:8], fcs[23:16], fcs[31:24]}) && (len >= 7'd64);
  end

  // Delay line, length counter and running CRC over bytes leaving the line.
  always_ff @(posedge clk) begin
    if (!rst_n || state == PRE) begin
      dly <= 32'h0;
      len <= 7'd0;
      crc <= 32'hFFFF_FFFF;
    end else if (gmii_rx_dv && (state == HEAD || state == DATA || state == CRC)) begin
      dly <= {dly[23:0], gmii_rxd};
      if (len != 7'd127) len <= len + 7'd1;
      if (len >= 7'd4)   crc <= crc_next;
    end
  end
`endif

  // Frame parser FSM with registered done/type/sender outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 6'd0;
      uni_ok      <= 1'b0;
      bc_ok       <= 1'b0;
      op_type     <= 1'b0;
      shadow_mac  <= 48'h0;
      shadow_ip   <= 32'h0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= 48'h0;
      src_ip      <= 32'h0;
    end else begin
      arp_rx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gmii_rx_dv && gmii_rxd == 8'h55) begin
            state <= PRE;
            cnt   <= 6'd1;
          end
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= 6'd0;
          end else if (gmii_rxd == 8'h55) begin
            if (cnt != 6'd63) cnt <= cnt + 6'd1;
          end else if (gmii_rxd == 8'hD5 && cnt >= 6'd6) begin
            state  <= HEAD;
            cnt    <= 6'd0;
            uni_ok <= 1'b1;
            bc_ok  <= 1'b1;
          end else begin
            state <= WAIT_END;
            cnt   <= 6'd0;
          end
        end
        HEAD: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= 6'd0;
          end else if (head_bad) begin
            state <= WAIT_END;
            cnt   <= 6'd0;
          end else begin
            if (cnt <= 6'd5) begin
              uni_ok <= uni_next;
              bc_ok  <= bc_next;
            end
            if (cnt == 6'd13) begin
              state <= DATA;
              cnt   <= 6'd0;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        DATA: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= 6'd0;
          end else if (data_bad) begin
            state <= WAIT_END;
            cnt   <= 6'd0;
          end else begin
            if (cnt == 6'd7) op_type <= gmii_rxd[1];
            if (cnt >= 6'd8 && cnt <= 6'd13) shadow_mac <= {shadow_mac[39:0], gmii_rxd};
            if (cnt >= 6'd14 && cnt <= 6'd17) shadow_ip <= {shadow_ip[23:0], gmii_rxd};
            if (cnt == 6'd27) begin
              cnt <= 6'd0;
`ifdef ARP_RX_CRC_CHK_EN
              state <= CRC;
`else
              state       <= WAIT_END;
              arp_rx_done <= 1'b1;
              arp_rx_type <= op_type;
              src_mac     <= shadow_mac;
              src_ip      <= shadow_ip;
`endif
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
`ifdef ARP_RX_CRC_CHK_EN
        CRC: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= 6'd0;
            if (fcs_ok) begin
              arp_rx_done <= 1'b1;
              arp_rx_type <= op_type;
              src_mac     <= shadow_mac;
              src_ip      <= shadow_ip;
            end
          end
        end
`endif
        WAIT_END: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= 6'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// tb_arp_rx: table-driven bench for arp_rx plus hand-written abort,
// back-to-back and mid-frame reset sequences. Builds under either setting
// of ARP_RX_CRC_CHK_EN.

module tb_arp_rx;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  always #4 clk = ~clk;

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt++;

  arp_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .arp_rx_done(arp_rx_done),
    .arp_rx_type(arp_rx_type),
    .src_mac    (src_mac),
    .src_ip     (src_ip)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame builder ----------------
  typedef struct {
    logic [47:0] dst;
    logic [15:0] etype;
    logic [15:0] op;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] tip;
    int          pre_len;
    bit          flip_fcs;
    bit          exp_done;
  } vec_t;

  logic [7:0] frm [0:127];
  int         frm_len;
  int         tip_idx;
  int         tip_drv;
  int         fall_drv;

  task automatic put(inout int idx, input logic [7:0] b);
    frm[idx] = b;
    idx++;
  endtask

  task automatic build(input vec_t v);
    int idx;
    int hdr;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    idx = 0;
    for (int i = 0; i < v.pre_len; i++) put(idx, 8'h55);
    put(idx, 8'hD5);
    hdr = idx;
    for (int i = 5; i >= 0; i--) put(idx, v.dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) put(idx, 8'hA0 + 8'(i));       // bench source MAC
    put(idx, v.etype[15:8]); put(idx, v.etype[7:0]);
    put(idx, 8'h00); put(idx, 8'h01); put(idx, 8'h08); put(idx, 8'h00);
    put(idx, 8'h06); put(idx, 8'h04);
    put(idx, v.op[15:8]); put(idx, v.op[7:0]);
    for (int i = 5; i >= 0; i--) put(idx, v.smac[8*i +: 8]);
    for (int i = 3; i >= 0; i--) put(idx, v.sip[8*i +: 8]);
    for (int i = 0; i < 6; i++)  put(idx, 8'h00);               // target MAC
    for (int i = 3; i >= 0; i--) put(idx, v.tip[8*i +: 8]);
    tip_idx = idx - 1;
    while (idx < hdr + 60) put(idx, 8'h00);                     // padding
    crc = 32'hFFFF_FFFF;
    for (int i = hdr; i < idx; i++) begin
      b = frm[i];
      for (int k = 0; k < 8; k++)
        crc = (crc[0] ^ b[k]) ? ((crc >> 1) ^ 32'hEDB8_8320) : (crc >> 1);
    end
    fcs = ~crc;
    put(idx, fcs[7:0]); put(idx, fcs[15:8]); put(idx, fcs[23:16]); put(idx, fcs[31:24]);
    if (v.flip_fcs) frm[idx-4] = frm[idx-4] ^ 8'h01;
    frm_len = idx;
  endtask

  // ---------------- driver ----------------
  // Sends the first cut bytes (whole frame if cut<0), then one cycle dv low.
  task automatic send(input int cut);
    int n;
    n = (cut < 0) ? frm_len : cut;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
      if (i == tip_idx) tip_drv = pos_cnt;
    end
    @(negedge clk);
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    fall_drv   = pos_cnt;
  endtask

  function automatic int exp_done_cyc();
`ifdef ARP_RX_CRC_CHK_EN
    return fall_drv + 1;
`else
    return tip_drv + 1;
`endif
  endfunction

  // ---------------- scoreboard ----------------
  logic [80:0] exp_q[$];
  logic [80:0] hold = '0;
  logic [80:0] exp_item;
  bit          mon_en = 1'b0;
  int          done_cnt = 0;
  int          done_cyc = 0;

  // Checks every done against the queue and that outputs hold between pulses.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      checks++;
      if (arp_rx_done) begin
        done_cnt++;
        done_cyc = pos_cnt;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got type=%0d mac=%0h ip=%0h with nothing expected",
                   arp_rx_type, src_mac, src_ip);
        end else begin
          exp_item = exp_q.pop_front();
          if ({arp_rx_type, src_mac, src_ip} !== exp_item) begin
            errors++;
            $display("FAIL done_fields: got %0h expected %0h", {arp_rx_type, src_mac, src_ip}, exp_item);
          end
          hold = exp_item;
        end
      end else if ({arp_rx_type, src_mac, src_ip} !== hold) begin
        errors++;
        $display("FAIL output_hold: got %0h expected %0h", {arp_rx_type, src_mac, src_ip}, hold);
      end
    end
  end

  // ---------------- test ----------------
  vec_t vecs [0:9];
  vec_t v;
  bit   exp_done;
  int   d0;
  int   want_cyc;

  task automatic run_vec(input int i, input vec_t tv);
    build(tv);
    exp_done = tv.exp_done;
`ifdef ARP_RX_CRC_CHK_EN
    if (tv.flip_fcs) exp_done = 1'b0;
`endif
    d0 = done_cnt;
    if (exp_done) exp_q.push_back({tv.op[1], tv.smac, tv.sip});
    send(-1);
    want_cyc = exp_done_cyc();
    @(negedge clk);
    chk($sformatf("vec%0d_done_count", i), 96'(done_cnt - d0), 96'(exp_done));
    if (exp_done) chk($sformatf("vec%0d_done_latency", i), 96'(done_cyc), 96'(want_cyc));
    chk($sformatf("vec%0d_outputs", i), 96'({arp_rx_type, src_mac, src_ip}), 96'(hold));
    exp_q.delete();
  endtask

  initial begin
    //           dst                  etype     op      smac                 sip           tip        pre flip done
    vecs[0] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 16'd1, 48'h02_00_00_00_00_01, 32'hC0A80164, 32'hC0A8010A, 7, 1'b0, 1'b1};
    vecs[1] = '{48'h0011_2233_4455, 16'h0806, 16'd2, 48'h02_00_00_00_00_14, 32'hC0A80114, 32'hC0A8010A, 7, 1'b0, 1'b1};
    vecs[2] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 16'd1, 48'h02_00_00_00_00_77, 32'hC0A80177, 32'hC0A8010B, 7, 1'b0, 1'b0};
    vecs[3] = '{48'h0011_2233_4456, 16'h0806, 16'd1, 48'h02_00_00_00_00_77, 32'hC0A80177, 32'hC0A8010A, 7, 1'b0, 1'b0};
    vecs[4] = '{48'hFFFF_FFFF_FFFF, 16'h0800, 16'd1, 48'h02_00_00_00_00_77, 32'hC0A80177, 32'hC0A8010A, 7, 1'b0, 1'b0};
    vecs[5] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 16'd1, 48'h02_00_00_00_00_77, 32'hC0A80177, 32'hC0A8010A, 3, 1'b0, 1'b0};
    vecs[6] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 16'd3, 48'h02_00_00_00_00_77, 32'hC0A80177, 32'hC0A8010A, 7, 1'b0, 1'b0};
    vecs[7] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 16'd1, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A80105, 32'hC0A8010A, 6, 1'b0, 1'b1};
    vecs[8] = '{48'hFFFF_FFFF_FFFF, 16'h0806, 16'd2, 48'h02_00_00_00_00_77, 32'hC0A80177, 32'hC0A8010A, 5, 1'b0, 1'b0};
    vecs[9] = '{48'h0011_2233_4455, 16'h0806, 16'd2, 48'h02_00_00_00_00_33, 32'hC0A80133, 32'hC0A8010A, 7, 1'b1, 1'b1};

    // reset values
    repeat (3) @(negedge clk);
    chk("reset_done", 96'(arp_rx_done), 96'd0);
    chk("reset_type", 96'(arp_rx_type), 96'd0);
    chk("reset_mac",  96'(src_mac), 96'd0);
    chk("reset_ip",   96'(src_ip), 96'd0);
    rst_n  = 1'b1;
    hold   = '0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // abort after HEAD byte 9, 1-cycle gap, then a valid request
    v = vecs[0];
    v.smac = 48'h02_00_00_00_00_55;
    v.sip  = 32'hC0A80155;
    build(vecs[2]);
    d0 = done_cnt;
    send(vecs[2].pre_len + 1 + 10);
    build(v);
    exp_q.push_back({v.op[1], v.smac, v.sip});
    send(-1);
    want_cyc = exp_done_cyc();
    @(negedge clk);
    chk("abort_then_valid_count", 96'(done_cnt - d0), 96'd1);
    chk("abort_then_valid_latency", 96'(done_cyc), 96'(want_cyc));
    exp_q.delete();

    // back-to-back valid frames with a 1-cycle gap
    d0 = done_cnt;
    build(vecs[1]);
    exp_q.push_back({vecs[1].op[1], vecs[1].smac, vecs[1].sip});
    send(-1);
    build(vecs[7]);
    exp_q.push_back({vecs[7].op[1], vecs[7].smac, vecs[7].sip});
    send(-1);
    want_cyc = exp_done_cyc();
    @(negedge clk);
    chk("back_to_back_count", 96'(done_cnt - d0), 96'd2);
    chk("back_to_back_latency", 96'(done_cyc), 96'(want_cyc));
    chk("back_to_back_src_ip", 96'(src_ip), 96'(vecs[7].sip));
    exp_q.delete();

    // reset in the middle of the ARP payload
    build(vecs[1]);
    for (int i = 0; i < vecs[1].pre_len + 1 + 14 + 10; i++) begin
      @(negedge clk);
      gmii_rx_dv = 1'b1;
      gmii_rxd   = frm[i];
    end
    @(negedge clk);
    mon_en     = 1'b0;
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (2) @(negedge clk);
    chk("midreset_done", 96'(arp_rx_done), 96'd0);
    chk("midreset_type", 96'(arp_rx_type), 96'd0);
    chk("midreset_mac",  96'(src_mac), 96'd0);
    chk("midreset_ip",   96'(src_ip), 96'd0);
    rst_n  = 1'b1;
    hold   = '0;
    exp_q.delete();
    @(negedge clk);
    mon_en = 1'b1;
    run_vec(10, vecs[0]);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 96'(exp_q.size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
